seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits (range 1..8).
REQ-002 Parameter PRESCALE, default 1000: clock cycles each digit is driven per visit (range 2..65535).
REQ-003 Parameter GAP_CYCLES, default 2: all-off cycles between digits for anti-ghosting (range 1..255).
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value  input  4*NUM_DIGITS  hex value; nibble i drives digit i, with digit 0 the least significant.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request, one bit per digit.
REQ-008 load  input  1  one-cycle strobe requesting capture of value and dp_in.
REQ-009 blank_lz  input  1  leading-zero suppression request; ignored unless SEG7_SCAN_LZ_EN is defined.
REQ-010 load_ack  output  1  one-cycle pulse when the captured data becomes the displayed data.
REQ-011 segments  output  8  registered segment drive, active-high; bit0 = segment 1 (top), ..., bit6 = segment 7 (middle), bit7 = decimal point.
REQ-012 digit_en  output  NUM_DIGITS  registered digit select, active-high, one-hot or all-zero.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHOW and GAP.
REQ-014 IDLE SHALL hold segments = 0 and digit_en = 0, and SHALL transition to SHOW with digit index 0 on the cycle after the first accepted load.
REQ-015 SHOW SHALL last exactly PRESCALE cycles, driving digit_en = (1 << idx) and segments = {dp[idx], hex pattern of nibble idx}.
REQ-016 GAP SHALL last exactly GAP_CYCLES cycles with segments = 0 and digit_en = 0, then SHALL enter SHOW with idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 One frame SHALL be exactly NUM_DIGITS*(PRESCALE+GAP_CYCLES) cycles.
REQ-018 The hex patterns SHALL be the team-standard seven-segment patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67, A=77, b=7C, c=58, d=5E, E=79, F=71.
REQ-019 A load SHALL copy value and dp_in into a pending register and set a pending flag.
REQ-020 A further load while pending is set SHALL overwrite the pending register (last wins), with no extra ack.
REQ-021 Pending data SHALL transfer to the display register on the GAP-to-SHOW transition into idx 0 (frame boundary) only, and load_ack SHALL pulse in that same cycle.
REQ-022 A load coinciding with the frame-boundary transfer cycle SHALL be transferred directly (the new data wins), with a single load_ack pulse.
REQ-023 The first load in IDLE SHALL be transferred immediately, with load_ack pulsing on the IDLE-to-SHOW cycle.
REQ-024 Displayed data SHALL never change mid-frame.
REQ-025 All outputs SHALL be registered, so the change on segments/digit_en aligns with the state change and has no combinational path from inputs.

Reset
REQ-026 While reset is high: state = IDLE, idx = 0, prescale and gap counters = 0, display and pending registers = 0, pending flag = 0, segments = 0, digit_en = 0, load_ack = 0.
REQ-027 Reset asserted mid-frame or mid-GAP SHALL take effect on the next edge, and a load in the same cycle as reset SHALL be discarded.

Configuration
REQ-028 With SEG7_SCAN_LZ_EN defined and blank_lz = 1, digit i > 0 SHALL show segments = {dp[i], 7'b0} when nibbles i..NUM_DIGITS-1 are all zero; digit_en timing SHALL be unchanged.
REQ-029 Without SEG7_SCAN_LZ_EN, blank_lz SHALL be ignored, all digits SHALL show their pattern, and the suppression logic SHALL be absent.

Structure
REQ-030 A shared package seg7_pkg SHALL hold the FSM state enum, the segment bit-index constants and the all-off segment constant.
REQ-031 The existing seg7hex decoder SHALL be instantiated once as the sole sub-module, fed by the selected nibble; its output SHALL be registered in seg7_scan.

Verification (NUM_DIGITS=4, PRESCALE=4, GAP_CYCLES=1)
REQ-032 Reset, then value=16'h1234 and load=1 for one cycle -> the next cycle has load_ack=1 and digit_en=0001 with segments=8'h66 for 4 cycles, followed by 1 all-off cycle and then digit_en=0010 with segments=8'h4F.
REQ-033 Frame check -> digit 3 shows 8'h06, and digit_en=0001 returns exactly 20 cycles after its previous rise.
REQ-034 Mid-frame load of 16'hABCD, then 16'hEF00 two cycles later -> exactly one load_ack at the next frame boundary, and digit 0 shows 8'h3F (value EF00).
REQ-035 value=16'h0005, dp_in=4'b0100, blank_lz=1: with the macro defined -> digits 1 and 3 show 8'h00 and digit 2 shows 8'h80; without the macro -> digits 1 and 3 show 8'h3F and digit 2 shows 8'hBF.
REQ-036 Reset pulsed during SHOW of digit 2 -> the next cycle has all outputs 0 and the state in IDLE, and the display stays dark until a new load.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the multiplexed seven-segment scanner:
//               FSM state encoding, segment bit positions and the all-off
//               segment value.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Scanner FSM states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } seg7_state_t;

    // Segment bit positions on the 8-bit segment bus.
    localparam int c_SEG_A  = 0;   // segment 1 (top)
    localparam int c_SEG_G  = 6;   // segment 7 (middle)
    localparam int c_SEG_DP = 7;   // decimal point

    // All segments dark.
    localparam logic [7:0] c_SEG_OFF = 8'h00;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7hex.sv
`default_nettype none
// ============================================================================
// Module      : seg7hex
// Description : Combinational hex-to-seven-segment decoder, active-high.
//               Bit 0 is the top segment, bit 6 the middle segment.
// Ports       : i_hex [3:0] - nibble to decode
//               o_seg [6:0] - segment pattern (no decimal point)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7hex (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h67;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h58;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule : seg7hex
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed hex display scanner. Each digit is driven for
//               PRESCALE cycles, followed by GAP_CYCLES all-off cycles. New
//               data is staged in a pending register and only takes effect at
//               a frame boundary, so a frame never shows mixed data.
// Options     : SEG7_SCAN_LZ_EN - when defined, blank_lz enables leading-zero
//               suppression on digits above digit 0.
// Ports       : clk       - clock, rising edge
//               reset     - synchronous active-high reset
//               value     - 4*NUM_DIGITS hex value, nibble i -> digit i
//               dp_in     - decimal point per digit
//               load      - capture strobe for value/dp_in
//               blank_lz  - leading-zero suppression request
//               load_ack  - pulses when captured data becomes displayed
//               segments  - registered segments {dp, g..a}, active-high
//               digit_en  - registered digit select, one-hot or zero
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    load_ack,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_W = 16;
    localparam int c_DAT_W = 4 * NUM_DIGITS;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_SHOW_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);

    // Scan state
    seg7_state_t          r_state;
    seg7_state_t          w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_frame_start;

    // Display / pending data
    logic [c_DAT_W-1:0]    r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [c_DAT_W-1:0]    r_pend_val;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend;
    logic [c_DAT_W-1:0]    w_disp_val_nxt;
    logic [NUM_DIGITS-1:0] w_disp_dp_nxt;
    logic                  w_xfer;

    // Output path
    logic [3:0]            w_nibble;
    logic [6:0]            w_hex_seg;
    logic                  w_lz;
    logic [7:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_den_nxt;
    logic [7:0]            r_segments;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_load_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. w_frame_start marks the cycle that enters digit 0,
    // either from IDLE on the first load or from the last GAP of a frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt   = ST_SHOW;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_frame_start = 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_cnt == c_SHOW_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt     = '0;
                        w_frame_start = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Display data selection. A load landing on the frame-start cycle
    // bypasses the pending register so the newest data wins. In IDLE the
    // pending flag is always clear, so the first load transfers directly.
    // ------------------------------------------------------------------
    always_comb begin
        w_xfer         = w_frame_start & (load | r_pend);
        w_disp_val_nxt = r_disp_val;
        w_disp_dp_nxt  = r_disp_dp;
        if (w_xfer) begin
            if (load) begin
                w_disp_val_nxt = value;
                w_disp_dp_nxt  = dp_in;
            end else begin
                w_disp_val_nxt = r_pend_val;
                w_disp_dp_nxt  = r_pend_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_disp_val <= w_disp_val_nxt;
            r_disp_dp  <= w_disp_dp_nxt;
            if (w_xfer) begin
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pend     <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression
    // ------------------------------------------------------------------
`ifdef SEG7_SCAN_LZ_EN
    // w_upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] w_upper_zero;

    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NUM_DIGITS-1] = (w_disp_val_nxt[c_DAT_W-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_upper_zero[i] = w_upper_zero[i+1] & (w_disp_val_nxt[4*i +: 4] == 4'h0);
        end
    end

    assign w_lz = blank_lz & (w_idx_nxt != '0) & w_upper_zero[w_idx_nxt];
`else
    logic w_unused_blank_lz;
    assign w_unused_blank_lz = blank_lz;
    assign w_lz              = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output logic. Decoded from next-state values so the registered
    // outputs change on the same edge as the state.
    // ------------------------------------------------------------------
    assign w_nibble = w_disp_val_nxt[4*w_idx_nxt +: 4];

    seg7hex u_seg7hex (
        .i_hex (w_nibble),
        .o_seg (w_hex_seg)
    );

    always_comb begin
        w_seg_nxt = c_SEG_OFF;
        w_den_nxt = '0;
        if (w_state_nxt == ST_SHOW) begin
            w_den_nxt[w_idx_nxt]         = 1'b1;
            w_seg_nxt[c_SEG_G:c_SEG_A]   = w_lz ? 7'h00 : w_hex_seg;
            w_seg_nxt[c_SEG_DP]          = w_disp_dp_nxt[w_idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_segments <= c_SEG_OFF;
            r_digit_en <= '0;
            r_load_ack <= 1'b0;
        end else begin
            r_segments <= w_seg_nxt;
            r_digit_en <= w_den_nxt;
            r_load_ack <= w_xfer;
        end
    end

    assign segments = r_segments;
    assign digit_en = r_digit_en;
    assign load_ack = r_load_ack;

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Self-checking bench for seg7_scan (4 digits, PRESCALE=4,
//               GAP_CYCLES=1). A frame-position reference model predicts every
//               output on every cycle; directed steps cover first load, frame
//               period, last-wins pending, leading zeros and mid-frame reset,
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

    localparam int ND    = 4;
    localparam int PRE   = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = PRE + GAP;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank_lz;
    logic          load_ack;
    logic [7:0]    segments;
    logic [3:0]    digit_en;

    seg7_scan #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PRE),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .load_ack (load_ack),
        .segments (segments),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Seven-segment table
    logic [6:0] hexpat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: display lifetime measured in cycles since activation
    bit          m_active;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    bit          m_pv;
    logic        exp_ack;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_en;

    // Observation helpers
    int          cyc = 0;
    int          last_rise = 0;
    int          rise_period = 0;
    bit          rise_seen = 0;
    logic [3:0]  prev_en = 4'b0;
    int          ack_count = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_update();
        int pos, d;
        logic [6:0] pat;
        exp_ack = 1'b0;
        if (reset) begin
            m_active = 0; m_t = 0; m_pv = 0;
            m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0;
        end else if (!m_active) begin
            if (load) begin
                m_active = 1; m_t = 0;
                m_disp = value; m_ddp = dp_in;
                exp_ack = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                if (load) begin
                    m_disp = value; m_ddp = dp_in; exp_ack = 1'b1;
                end else if (m_pv) begin
                    m_disp = m_pend; m_ddp = m_pdp; exp_ack = 1'b1;
                end
                m_pv = 0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_in; m_pv = 1;
            end
        end
        exp_seg = 8'h00;
        exp_en  = 4'h0;
        if (m_active) begin
            pos = m_t % FRAME;
            d   = pos / SLOT;
            if (pos % SLOT < PRE) begin
                exp_en = 4'(1 << d);
                pat = hexpat[(m_disp >> (4 * d)) & 16'hF];
`ifdef SEG7_SCAN_LZ_EN
                if (blank_lz && d > 0 && (m_disp >> (4 * d)) == 16'h0) pat = 7'h00;
`endif
                exp_seg = {m_ddp[d], pat};
            end
        end
    endtask

    // One clock: model samples the same inputs as the DUT, outputs checked 1 after the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        chk("segments", segments, exp_seg);
        chk("digit_en", {4'b0, digit_en}, {4'b0, exp_en});
        chk("load_ack", {7'b0, load_ack}, {7'b0, exp_ack});
        if (digit_en == 4'b0001 && prev_en != 4'b0001) begin
            rise_period = cyc - last_rise;
            last_rise   = cyc;
            rise_seen   = 1;
        end
        prev_en = digit_en;
        if (load_ack) ack_count++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] cap1, cap2;
    int         k;

    initial begin
        reset = 1'b1; value = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
        steps(3);
        reset = 1'b0;
        steps(2);

        // First load in IDLE: immediate transfer
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        chk("first_ack",  {7'b0, load_ack}, 8'h01);
        chk("first_en",   {4'b0, digit_en}, 8'h01);
        chk("first_seg",  segments, 8'h66);
        steps(4);
        chk("gap_seg", segments, 8'h00);
        step();
        chk("digit1_en",  {4'b0, digit_en}, 8'h02);
        chk("digit1_seg", segments, 8'h4F);

        // Frame period from one digit-0 rise to the next
        rise_seen = 0;
        k = 0;
        while (!rise_seen && k < 40) begin step(); k++; end
        chk("frame_period", 8'(rise_period), 8'(FRAME));

        // Mid-frame double load: last wins, single ack
        steps(3);
        ack_count = 0;
        value = 16'hABCD; load = 1'b1; step();
        load = 1'b0; step();
        value = 16'hEF00; load = 1'b1; step();
        load = 1'b0;
        steps(25);
        chk("ack_count", 8'(ack_count), 8'h01);

        // Leading zero suppression
        value = 16'h0005; dp_in = 4'b0100; blank_lz = 1'b1; load = 1'b1; step();
        load = 1'b0;
        steps(FRAME + 2);
        cap1 = 8'hFF; cap2 = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (digit_en == 4'b0010) cap1 = segments;
            if (digit_en == 4'b0100) cap2 = segments;
        end
`ifdef SEG7_SCAN_LZ_EN
        chk("lz_digit1", cap1, 8'h00);
        chk("lz_digit2", cap2, 8'h80);
`else
        chk("lz_digit1", cap1, 8'h3F);
        chk("lz_digit2", cap2, 8'hBF);
`endif
        blank_lz = 1'b0; dp_in = 4'b0;

        // Reset during SHOW of digit 2, with a load in the same cycle
        k = 0;
        while (digit_en != 4'b0100 && k < 40) begin step(); k++; end
        chk("wait_digit2", {4'b0, digit_en}, 8'h04);
        step();
        reset = 1'b1; load = 1'b1; value = 16'h9999; step();
        reset = 1'b0; load = 1'b0;
        chk("rst_seg", segments, 8'h00);
        chk("rst_en",  {4'b0, digit_en}, 8'h00);
        chk("rst_ack", {7'b0, load_ack}, 8'h00);
        steps(30);
        chk("dark_en", {4'b0, digit_en}, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0;
        steps(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan
`default_nettype wire
